t09_frame_scan_ctrl: RTL
========================

# t09_frame_scan_ctrl

Sequencer for the t09 frame tracker: runs one 16x12 cell scan per game frame by driving the tracker's `enable`/`sync`, captures each changed cell (`diff`) into a small update FIFO, and presents the FIFO head to the display writer over a valid/ready handshake. It throttles the scan so no change is lost while the writer is slow. It sits between the game tick/frame-start logic and the display pixel writer.

## Interface
Parameters:
- `GRID_W`, default 16: cells per row; the tracker's x counts 0..GRID_W-1 first.
- `GRID_H`, default 12: rows; y counts 0..GRID_H-1.
- `FIFO_DEPTH`, default 4: update FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle request to scan a frame.
- `redraw` in 1: sampled with `frame_start`; forces a full redraw through `sync`.
- `diff` in 1: tracker changed-cell flag, combinational, for the tracker's current cell.
- `trk_x` in 4, `trk_y` in 4, `obj_code` in 3: tracker's current cell and its new code.
- `trk_enable` out 1: advance the tracker one cell.
- `trk_sync` out 1: tracker clear and home to (0,0).
- `upd_valid` out 1, `upd_ready` in 1: update handshake.
- `upd_x` out 4, `upd_y` out 4, `upd_code` out 3: FIFO head entry.
- `busy` out 1: high when the state is not IDLE.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `upd_drop` out 1: sticky flag; a `diff` arrived while the FIFO was full.
- `dirty_count` out 8: number of updates pushed during the last frame (see Configuration).

## Operation
- States:
  - IDLE → SCAN on `frame_start` with `redraw`=0.
  - IDLE → SYNC on `frame_start` with `redraw`=1.
  - SYNC → SCAN after exactly 1 cycle.
  - SCAN → DRAIN on the cycle `trk_enable` is issued with cell counter = GRID_W*GRID_H-1 (191).
  - DRAIN → IDLE when the FIFO is empty. `frame_done` pulses on that transition.
- `frame_start` outside IDLE is ignored; no queuing.
- `trk_sync` = (state==SYNC). It also clears `upd_drop`.
- Capture runs in every state:
  - `push` = `diff` && !full; the entry is {`trk_x`, `trk_y`, `obj_code`}.
  - `diff` && full sets `upd_drop`.
  - The tracker commits its frame memory every cycle, so `diff` for a cell is seen once. It is never re-sampled.
- Pop: `pop` = `upd_valid` && `upd_ready`. Push and pop in the same cycle are both performed; count is unchanged.
- `count_next` = count + push − pop.
- `trk_enable` = (state==SCAN) && (`count_next` < FIFO_DEPTH). This guarantees one free slot when the tracker arrives at the next cell.
- Cell counter:
  - 8-bit, cleared on entry to SCAN, incremented on each `trk_enable`.
  - The 192nd enable wraps the tracker to (0,0), ready for the next frame.
- FIFO is show-ahead: `upd_*` show the head whenever `upd_valid`=1. `upd_valid` = !empty.
- Reset values: state IDLE; FIFO empty; cell counter 0; all outputs 0.
- Reset mid-frame aborts the frame. FIFO contents are discarded and no `frame_done` is issued.

## Timing
- `trk_enable`, `trk_sync`, `upd_valid` and `upd_*` are combinational from registered state and FIFO count. `trk_enable` also depends on this cycle's `diff` and `upd_ready`.
- `frame_start` → first `trk_enable`: 1 cycle (redraw=0) or 2 cycles (redraw=1).
- Push latency: an entry captured in cycle N is visible on `upd_*` in cycle N+1.
- With `upd_ready` held high the scan never stalls. A frame is 192 SCAN cycles plus at most 1 DRAIN cycle.
- `upd_ready` low stalls the scan at most until a slot frees. A stalled cell holds the tracker position and does not lose its capture.

## Configuration
- `T09_DIRTY_COUNT_EN` defined:
  - An 8-bit counter increments on each push while `busy`.
  - It is copied to `dirty_count` in the `frame_done` cycle and cleared on the next frame start.
- Not defined: `dirty_count` is tied to 0 and no counter flops exist.

## Structure
- Shared package `t09_pkg`:
  - Object code constants: EMPTY=3'b000, HEAD=3'b001, BODY=3'b010, APPLE=3'b011, BORDER=3'b100.
  - State enum typedef.
  - Update-entry struct typedef {x, y, code}.
- Sub-module `t09_upd_fifo`: synchronous, show-ahead, parameterized by depth and entry width. It exposes push, pop, head, count, full and empty. The controller holds the FSM and the cell counter.

## Test plan
- Steady frame: `frame_start`, `redraw`=0, `upd_ready`=1, `diff` pulsed at the cells (3,2) and (15,11). Required: exactly 192 `trk_enable` cycles, and entries (3,2,code) then (15,11,code) on `upd_*`. `frame_done` 1 cycle after the last enable; `busy` low after that.
- Redraw: `frame_start`+`redraw`=1. Required: `trk_sync` high for exactly 1 cycle, the first `trk_enable` the following cycle, and `upd_drop` cleared.
- Backpressure: `upd_ready`=0, `diff`=1 at 5 consecutive cells. Required: `trk_enable` drops once count would reach 4, 4 entries held and `upd_drop`=0. Releasing `upd_ready` drains them in order and the scan resumes.
- Simultaneous push/pop with a full FIFO and `diff`=1: count stays 4 and no drop occurs.
- `frame_start` during SCAN is ignored, with 192 enables total. Asserting `nrst` mid-SCAN gives state IDLE, `upd_valid`=0 and no `frame_done`.
- With `T09_DIRTY_COUNT_EN`: 7 diffs in a frame → `dirty_count`=7 from the `frame_done` cycle onward. Without the macro → `dirty_count` stays 0.

Source files
------------

// File: rtl/t09_pkg.sv
// Shared types for the t09 frame tracker: object codes, scan FSM states and
// the update-FIFO entry layout.
package t09_pkg;

  localparam logic [2:0] OBJ_EMPTY  = 3'b000;
  localparam logic [2:0] OBJ_HEAD   = 3'b001;
  localparam logic [2:0] OBJ_BODY   = 3'b010;
  localparam logic [2:0] OBJ_APPLE  = 3'b011;
  localparam logic [2:0] OBJ_BORDER = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] code;
  } upd_entry_t;

  localparam int UPD_W = $bits(upd_entry_t);

endpackage

// File: rtl/t09_upd_fifo.sv
// Synchronous show-ahead FIFO for cell updates; the head is valid whenever
// the FIFO is non-empty. DEPTH must be a power of two.
module t09_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  always_comb begin
    do_pop  = pop && !empty;
    // When full, the slot being written is the one the head vacates.
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/t09_frame_scan_ctrl.sv
// Frame scan sequencer: steps the tracker over the grid once per frame and
// queues changed cells for the display writer. Optional T09_DIRTY_COUNT_EN
// adds a per-frame pushed-update counter on dirty_count.
module t09_frame_scan_ctrl
  import t09_pkg::*;
#(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       frame_start,
  input  logic       redraw,
  input  logic       diff,
  input  logic [3:0] trk_x,
  input  logic [3:0] trk_y,
  input  logic [2:0] obj_code,
  output logic       trk_enable,
  output logic       trk_sync,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [3:0] upd_x,
  output logic [3:0] upd_y,
  output logic [2:0] upd_code,
  output logic       busy,
  output logic       frame_done,
  output logic       upd_drop,
  output logic [7:0] dirty_count
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_CELL = 8'(GRID_W * GRID_H - 1);

  state_e        state_q, state_d;
  logic [7:0]    cell_q, cell_d;
  logic          drop_q, drop_d;
  logic          push, pop, full, empty, room;
  logic [CW-1:0] fifo_count, count_next;
  upd_entry_t    wr_s, head_s;
  logic [UPD_W-1:0] head_raw;

  assign wr_s = '{x: trk_x, y: trk_y, code: obj_code};

  t09_upd_fifo #(.DEPTH(FIFO_DEPTH), .W(UPD_W)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_s),
    .head  (head_raw),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign head_s    = upd_entry_t'(head_raw);
  assign upd_valid = !empty;
  assign upd_x     = head_s.x;
  assign upd_y     = head_s.y;
  assign upd_code  = head_s.code;
  assign busy      = (state_q != ST_IDLE);
  assign trk_sync  = (state_q == ST_SYNC);
  assign upd_drop  = drop_q;

  always_comb begin
    pop  = upd_valid && upd_ready;
    // A full FIFO can still take a capture in the cycle its head leaves.
    room = !full || pop;
    push = diff && room;
    count_next = fifo_count + CW'(push) - CW'(pop);
    trk_enable = (state_q == ST_SCAN) && (count_next < CW'(FIFO_DEPTH));
    drop_d     = (drop_q && !trk_sync) || (diff && !room);

    state_d    = state_q;
    cell_d     = cell_q;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: if (frame_start) begin
        state_d = redraw ? ST_SYNC : ST_SCAN;
        cell_d  = '0;
      end
      ST_SYNC: begin
        state_d = ST_SCAN;
        cell_d  = '0;
      end
      ST_SCAN: if (trk_enable) begin
        cell_d = cell_q + 8'd1;
        if (cell_q == LAST_CELL) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (count_next == '0) begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cell_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      drop_q  <= drop_d;
    end
  end

`ifdef T09_DIRTY_COUNT_EN
  logic [7:0] dcnt_q, dcnt_d, dirty_q, dirty_d;

  // Nothing is pushed in the frame_done cycle, so dcnt_q is already final.
  always_comb begin
    dcnt_d = dcnt_q;
    if (state_q == ST_IDLE && frame_start) dcnt_d = '0;
    else if (push && busy)                 dcnt_d = dcnt_q + 8'd1;
    dirty_d = frame_done ? dcnt_q : dirty_q;
  end

  assign dirty_count = frame_done ? dcnt_q : dirty_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dcnt_q  <= '0;
      dirty_q <= '0;
    end else begin
      dcnt_q  <= dcnt_d;
      dirty_q <= dirty_d;
    end
  end
`else
  assign dirty_count = '0;
`endif

endmodule
